// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiply unit: op encodings, the
// width-independent stage control payload, and operand signedness helpers.
// No logic of its own; imported by the interface and the top.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  // Control carried through stage 1 alongside the partial products.
  typedef struct packed {
    logic    neg;
    mul_op_e op;
  } mul_ctl_t;

  // rs1 is signed for MULH and MULHSU.
  function automatic logic x_signed(input mul_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  // rs2 is signed for MULH only.
  function automatic logic y_signed(input mul_op_e op);
    return (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/mul_pipe_unit_if.sv
// Handshake bundle for the multiply unit: op request side and result side.
// master: op issuer / result consumer.  slave: the multiply unit.
// Both directions use valid/ready; a transfer happens when both are high.
interface mul_pipe_unit_if
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
);

  logic                  in_valid_i;
  logic                  in_ready_o;
  mul_op_e               op_i;
  logic [DATA_WIDTH-1:0] x_i;
  logic [DATA_WIDTH-1:0] y_i;
  logic [TAG_WIDTH-1:0]  tag_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic [TAG_WIDTH-1:0]  tag_o;

  modport master (
    output in_valid_i, op_i, x_i, y_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, tag_o
  );

  modport slave (
    input  in_valid_i, op_i, x_i, y_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, tag_o
  );

endinterface

// File: rtl/mul_pp_gen.sv
// Four half-width limb multiplies of two unsigned magnitudes (combinational).
// Ports: x_i/y_i magnitudes in; pp_ll/pp_lh/pp_hl/pp_hh products out (W bits each).
// Latency 0; no flow control.
module mul_pp_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  output logic [DATA_WIDTH-1:0] pp_ll_o,
  output logic [DATA_WIDTH-1:0] pp_lh_o,
  output logic [DATA_WIDTH-1:0] pp_hl_o,
  output logic [DATA_WIDTH-1:0] pp_hh_o
);

  localparam int W = DATA_WIDTH;
  localparam int H = W / 2;

  // Zero-extend each limb to W bits so an H x H product never truncates.
  logic [W-1:0] xl, xh, yl, yh;

  assign xl = {{H{1'b0}}, x_i[H-1:0]};
  assign xh = {{H{1'b0}}, x_i[W-1:H]};
  assign yl = {{H{1'b0}}, y_i[H-1:0]};
  assign yh = {{H{1'b0}}, y_i[W-1:H]};

  // pp_lh = x_lo*y_hi, pp_hl = x_hi*y_lo; both weigh 2^H.
  assign pp_ll_o = xl * yl;
  assign pp_lh_o = xl * yh;
  assign pp_hl_o = xh * yl;
  assign pp_hh_o = xh * yh;

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined RV32M/RV64M multiplier (MUL, MULH, MULHSU, MULHU), one op per cycle.
// Latency: 2 register stages (partial products, then summed/selected result).
// Backpressure: each stage holds while blocked; in_ready_o = stage 1 can advance.
// Ports: clk_i, reset_i (async, active-high), bus (mul_pipe_unit_if.slave),
//   flush_i only when MUL_FLUSH_EN is defined (kills both stages, wins over accept).
module mul_pipe_unit
  import mul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input logic clk_i,
  input logic reset_i,
`ifdef MUL_FLUSH_EN
  input logic flush_i,
`endif
  mul_pipe_unit_if.slave bus
);

  localparam int W = DATA_WIDTH;
  localparam int H = W / 2;

  typedef struct packed {
    logic [W-1:0]         pp_ll;
    logic [W-1:0]         pp_lh;
    logic [W-1:0]         pp_hl;
    logic [W-1:0]         pp_hh;
    mul_ctl_t             ctl;
    logic [TAG_WIDTH-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [W-1:0]         result;
    logic [TAG_WIDTH-1:0] tag;
  } s2_t;

  // ---------------- stage 0: sign handling and limb products ----------------
  logic         x_neg, y_neg;
  logic [W-1:0] x_mag, y_mag;
  logic [W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  assign x_neg = x_signed(bus.op_i) & bus.x_i[W-1];
  assign y_neg = y_signed(bus.op_i) & bus.y_i[W-1];
  // -2^(W-1) negates to itself, which is exactly its unsigned magnitude.
  assign x_mag = x_neg ? -bus.x_i : bus.x_i;
  assign y_mag = y_neg ? -bus.y_i : bus.y_i;

  mul_pp_gen #(.DATA_WIDTH(W)) u_pp_gen (
    .x_i    (x_mag),
    .y_i    (y_mag),
    .pp_ll_o(pp_ll),
    .pp_lh_o(pp_lh),
    .pp_hl_o(pp_hl),
    .pp_hh_o(pp_hh)
  );

  // ---------------- pipeline state ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;

  // ---------------- stage 2 comb: sum, sign-correct, select ----------------
  logic [W:0]     mid_sum;
  logic [2*W-1:0] p_mag, p_fix;
  logic [W-1:0]   result_sel;

  always_comb begin
    // Middle terms summed in W+1 bits so their carry is kept.
    mid_sum    = {1'b0, s1_q.pp_lh} + {1'b0, s1_q.pp_hl};
    p_mag      = {s1_q.pp_hh, {W{1'b0}}}
               + {{(H-1){1'b0}}, mid_sum, {H{1'b0}}}
               + {{W{1'b0}}, s1_q.pp_ll};
    p_fix      = s1_q.ctl.neg ? -p_mag : p_mag;
    result_sel = (s1_q.ctl.op == MUL_OP_MUL) ? p_fix[W-1:0] : p_fix[2*W-1:W];
  end

  // ---------------- flow control and next state ----------------
  logic adv1, adv2, in_ready, accept;

  always_comb begin
    adv2     = !s2_valid_q || bus.out_ready_i;
    adv1     = !s1_valid_q || adv2;
`ifdef MUL_FLUSH_EN
    in_ready = adv1 && !flush_i;
`else
    in_ready = adv1;
`endif
    accept   = bus.in_valid_i && in_ready;

    s1_valid_d = adv1 ? accept : s1_valid_q;
    s1_d       = s1_q;
    if (accept) begin
      s1_d.pp_ll   = pp_ll;
      s1_d.pp_lh   = pp_lh;
      s1_d.pp_hl   = pp_hl;
      s1_d.pp_hh   = pp_hh;
      s1_d.ctl.neg = x_neg ^ y_neg;
      s1_d.ctl.op  = bus.op_i;
      s1_d.tag     = bus.tag_i;
    end

    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    s2_d       = s2_q;
    if (adv2 && s1_valid_q) begin
      s2_d.result = result_sel;
      s2_d.tag    = s1_q.tag;
    end

`ifdef MUL_FLUSH_EN
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = s2_valid_q;
  assign bus.result_o    = s2_q.result;
  assign bus.tag_o       = s2_q.tag;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Self-checking bench for mul_pipe_unit (W=32): directed corners, latency,
// stall/hold, async reset, optional flush, then randomized traffic vs a model.
module tb_mul_pipe_unit;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef MUL_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  mul_pipe_unit_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

  mul_pipe_unit #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk_i  (clk),
    .reset_i(rst),
`ifdef MUL_FLUSH_EN
    .flush_i(flush),
`endif
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int nout     = 0;

  logic [36:0] exp_q[$];   // {tag, result}

  logic        s_ov, s_ir, in_fire, out_fire;
  logic [31:0] s_res;
  logic [4:0]  s_tag;

  task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: extend each operand to 64 bits per its signedness, multiply, pick half.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] a, b, p;
    a = (op == 2'b01 || op == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
    b = (op == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
    p = a * b;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // One cycle: drive at negedge, sample 1ns later, score transfers, wait for the edge.
  task automatic step(input logic iv, input logic [1:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [4:0] tag, input logic ordy);
    logic [36:0] e;
    @(negedge clk);
    bus.in_valid_i  = iv;
    bus.op_i        = mul_op_e'(op);
    bus.x_i         = x;
    bus.y_i         = y;
    bus.tag_i       = tag;
    bus.out_ready_i = ordy;
    #1;
    s_ov     = bus.out_valid_o;
    s_ir     = bus.in_ready_o;
    s_res    = bus.result_o;
    s_tag    = bus.tag_o;
    in_fire  = iv & s_ir;
    out_fire = s_ov & ordy;
    if (out_fire) begin
      nout++;
      if (exp_q.size() == 0) check_val("spurious_out", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check_val("result", {32'b0, s_res}, {32'b0, e[31:0]});
        check_val("tag", {59'b0, s_tag}, {59'b0, e[36:32]});
      end
    end
    if (in_fire) exp_q.push_back({tag, ref_mul(op, x, y)});
    @(posedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'b00, 32'h0, 32'h0, 5'h0, ordy);
  endtask

  // Single op into an empty pipe: not visible after one edge, visible after two.
  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] tag, input logic [31:0] exp);
    step(1'b1, op, x, y, tag, 1'b1);
    check_val({name, "_acc"}, {63'b0, in_fire}, 64'd1);
    idle(1'b1);
    check_val({name, "_lat1"}, {63'b0, s_ov}, 64'd0);
    idle(1'b1);
    check_val({name, "_vld"}, {63'b0, s_ov}, 64'd1);
    check_val({name, "_res"}, {32'b0, s_res}, {32'b0, exp});
    check_val({name, "_tag"}, {59'b0, s_tag}, {59'b0, tag});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] corners [5];
    logic [31:0] held;
    logic [31:0] rx, ry;
    int          n0;
    bit          got;
    corners[0] = 32'h0;        corners[1] = 32'h1;        corners[2] = 32'h8000_0000;
    corners[3] = 32'hFFFF_FFFF; corners[4] = 32'h7FFF_FFFF;

    bus.in_valid_i = 1'b0; bus.op_i = MUL_OP_MUL; bus.x_i = '0; bus.y_i = '0;
    bus.tag_i = '0; bus.out_ready_i = 1'b0;

    // Reset state
    #2;
    check_val("rst_out_valid", {63'b0, bus.out_valid_o}, 64'd0);
    check_val("rst_result", {32'b0, bus.result_o}, 64'd0);
    check_val("rst_tag", {59'b0, bus.tag_o}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_in_ready", {63'b0, bus.in_ready_o}, 64'd1);

    // Directed corners
    directed("mul_7x-3", 2'b00, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB);
    directed("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000);
    directed("mulhu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE);
    directed("mulhsu_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 32'hFFFF_FFFF);
    directed("mulh_neg_zero", 2'b01, 32'h0, 32'hFFFF_FFFB, 5'd1, 32'h0);

    // Back-to-back: 8 ops then 2 idles -> 8 consecutive results
    n0 = nout;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'($urandom), $urandom, $urandom, 5'(i), 1'b1);
      check_val("b2b_acc", {63'b0, in_fire}, 64'd1);
    end
    idle(1'b1); idle(1'b1);
    check_val("b2b_count", 64'(nout - n0), 64'd8);

    // Stall: 3 ops with out_ready low for 5 cycles
    n0 = nout;
    step(1'b1, 2'b00, 32'd100, 32'd200, 5'd21, 1'b0);
    check_val("stall_acc0", {63'b0, in_fire}, 64'd1);
    step(1'b1, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 5'd22, 1'b0);
    check_val("stall_acc1", {63'b0, in_fire}, 64'd1);
    step(1'b1, 2'b01, 32'hFFFF_FF00, 32'h0000_0F00, 5'd23, 1'b0);
    check_val("stall_blocked", {63'b0, in_fire}, 64'd0);
    held = s_res;
    for (int i = 0; i < 4; i++)
      step(1'b1, 2'b01, 32'hFFFF_FF00, 32'h0000_0F00, 5'd23, 1'b0);
    check_val("stall_ready_low", {63'b0, s_ir}, 64'd0);
    check_val("stall_hold_vld", {63'b0, s_ov}, 64'd1);
    check_val("stall_hold_res", {32'b0, s_res}, {32'b0, held});
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step(1'b1, 2'b01, 32'hFFFF_FF00, 32'h0000_0F00, 5'd23, 1'b1);
      got = in_fire;
    end
    check_val("stall_release_acc", {63'b0, got}, 64'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_val("stall_delivered", 64'(nout - n0), 64'd3);
    check_val("stall_empty", 64'(exp_q.size()), 64'd0);

    // Async reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, $urandom, $urandom, 5'(i), 1'b1);
    #1;
    check_val("prereset_vld", {63'b0, bus.out_valid_o}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("reset_drop_vld", {63'b0, bus.out_valid_o}, 64'd0);
    exp_q.delete();
    bus.in_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("reset_rel_ready", {63'b0, bus.in_ready_o}, 64'd1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_val("reset_no_stale", {63'b0, s_ov}, 64'd0);

`ifdef MUL_FLUSH_EN
    // Flush with 2 ops in flight
    step(1'b1, 2'b00, 32'd5, 32'd6, 5'd11, 1'b1);
    step(1'b1, 2'b00, 32'd7, 32'd8, 5'd12, 1'b1);
    @(negedge clk);
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b0;
    flush = 1'b1;
    #1;
    check_val("flush_ready_low", {63'b0, bus.in_ready_o}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    check_val("flush_no_vld", {63'b0, bus.out_valid_o}, 64'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) idle(1'b1);
    directed("post_flush", 2'b00, 32'd9, 32'd9, 5'd13, 32'd81);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rx = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      ry = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      step(1'($urandom_range(0, 1)), 2'($urandom), rx, ry, 5'($urandom),
           ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);
    check_val("rand_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
